// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, word}; head is read straight from the storage flops.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output logic [W-1:0]                 head_data
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A push into a full FIFO is only accepted when the head leaves the same cycle.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, in-order imem requests, prefetch buffering
// and redirect flush with discard of in-flight responses.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int         N        = 32,
    parameter int         DEPTH    = 2,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [N-1:0]       imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [N-1:0]       redirect_pc,
    output logic [INSTR_W-1:0] opcode,
    output logic [N-1:0]       opcode_pc,
    output logic               opcode_valid,
    input  logic               opcode_ready
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int FW = N + INSTR_W;

    fetch_state_e  state_q, state_d;
    logic [N-1:0]  pc_q, pc_d;
    logic [N-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] occ;
    logic [CW:0]   load;
    logic          accept, rsp_fire, keep, pop;
    logic [FW-1:0] head_data;

    // Request gating looks only at registered state so imem never sees a comb loop.
    assign load           = {1'b0, occ} + {1'b0, inflight_q};
    assign imem_req_valid = !rst && (state_q == FETCH) && (load < (CW+1)'(DEPTH));
    assign imem_addr      = pc_q;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
    assign keep     = rsp_fire && (drop_q == '0) && !redirect_valid;
    assign pop      = opcode_valid && opcode_ready && !redirect_valid;

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        state_d    = state_q;
        inflight_d = inflight_q + CW'(accept) - CW'(rsp_fire);
        if (accept) begin
            pc_d = pc_q + N'(PC_STEP);
        end
        if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if (keep) begin
            rsp_pc_d = rsp_pc_q + N'(PC_STEP);
        end
        if ((state_q == FLUSH) && (drop_d == '0)) begin
            state_d = FETCH;
        end
        // Everything still outstanding after this cycle belongs to the old stream.
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rsp_pc_d = redirect_pc;
            drop_d   = inflight_d;
            state_d  = (inflight_d != '0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid),
        .push       (keep),
        .push_data  ({rsp_pc_q, imem_rsp_data}),
        .pop        (pop),
        .count      (occ),
        .head_valid (opcode_valid),
        .head_data  (head_data)
    );

    assign opcode_pc = head_data[FW-1:INSTR_W];
    assign opcode    = head_data[INSTR_W-1:0];
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a queue-based memory and stream model.
module tb_instr_fetch;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, rsp_valid, redir_v, op_valid, op_ready;
    logic [31:0] imem_addr, rsp_data, redir_pc, opcode, opcode_pc;

    always #5 clk = ~clk;

    instr_fetch #(.N(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .redirect_valid (redir_v),
        .redirect_pc    (redir_pc),
        .opcode         (opcode),
        .opcode_pc      (opcode_pc),
        .opcode_valid   (op_valid),
        .opcode_ready   (op_ready)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
        bit          live;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] got_pc[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, last_due = 0, lat = 1;
    int          acc_live = 0, del_live = 0, n_del = 0, first_del_cyc = -1;
    bit          rand_rdy = 0, rand_dec = 0, hold_pend = 0;
    logic [31:0] exp_fetch, exp_del, hold_op, hold_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic int live_out();
        int l = 0;
        foreach (memq[i]) if (memq[i].live) l++;
        return l;
    endfunction

    // Words sitting in the prefetch buffer: kept responses not yet handed to decode.
    function automatic int buffered();
        return acc_live - del_live - live_out();
    endfunction

    task automatic tick();
        int  due, sum, dead;
        bit  exp_req;
        if (rand_rdy) req_ready = 1'($urandom_range(0, 1));
        if (rand_dec) op_ready  = 1'($urandom_range(0, 1));
        rsp_valid = 1'b0;
        rsp_data  = '0;
        if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = word_of(memq[0].addr);
        end
        #1;
        if (rst) begin
            memq.delete();
            last_due  = 0;
            exp_fetch = RST_PC;
            exp_del   = RST_PC;
            acc_live  = 0;
            del_live  = 0;
            hold_pend = 0;
            chk("req_in_rst", 32'(req_valid), 0);
        end else begin
            sum     = buffered() + memq.size();
            dead    = memq.size() - live_out();
            exp_req = (dead == 0) && (sum < DEPTH);
            chk("req_valid", 32'(req_valid), 32'(exp_req));
            chk("op_valid", 32'(op_valid), 32'(buffered() > 0));
            if (hold_pend) begin
                chk("hold_pc", opcode_pc, hold_pc);
                chk("hold_op", opcode, hold_op);
            end
            if (op_valid && op_ready && !redir_v) begin
                chk("op_pc", opcode_pc, exp_del);
                chk("op_word", opcode, word_of(exp_del));
                got_pc.push_back(opcode_pc);
                exp_del += 4;
                del_live++;
                n_del++;
                if (first_del_cyc < 0) first_del_cyc = cyc;
            end
            hold_pend = op_valid && !op_ready && !redir_v;
            hold_op   = opcode;
            hold_pc   = opcode_pc;
            if (req_valid && req_ready) begin
                chk("req_addr", imem_addr, exp_fetch);
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                memq.push_back('{due: due, addr: exp_fetch, live: !redir_v});
                last_due  = due;
                exp_fetch += 4;
                if (!redir_v) acc_live++;
            end
            if (rsp_valid) void'(memq.pop_front());
            if (redir_v) begin
                exp_fetch = redir_pc;
                exp_del   = redir_pc;
                acc_live  = 0;
                del_live  = 0;
                foreach (memq[i]) memq[i].live = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int rel0, r, d1, n, nd;
        rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
        redir_v = 1'b0; redir_pc = '0; op_ready = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_op_valid", 32'(op_valid), 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_opcode_pc", opcode_pc, 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("first_req", 32'(req_valid), 1);

        // Streaming from the wrap-around reset PC with a 1-cycle memory.
        got_pc.delete();
        first_del_cyc = -1;
        rel0 = cyc;
        lat  = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("first_lat", 32'(first_del_cyc - rel0), 2);
        chk("wrap0", got_pc[0], 32'hFFFF_FFFC);
        chk("wrap1", got_pc[1], 32'h0000_0000);
        chk("wrap2", got_pc[2], 32'h0000_0004);
        chk("stream_rate", 32'(n_del >= 10), 1);

        // Decode stall: buffer fills to DEPTH and requests stop.
        op_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_buf", 32'(buffered()), DEPTH);
        chk("stall_noreq", 32'(req_valid), 0);
        chk("stall_inflight", 32'(memq.size()), 0);
        nd = n_del;
        op_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_release", 32'(n_del - nd >= DEPTH), 1);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        for (int i = 0; i < 50 && !(memq.size() == 2 && memq[0].due > cyc && buffered() == 0); i++) tick();
        chk("wait_two_inflight", 32'(memq.size() == 2 && memq[0].due > cyc && buffered() == 0), 1);
        r  = cyc;
        d1 = memq[memq.size()-1].due;
        redir_v = 1'b1; redir_pc = 32'h100;
        tick();
        redir_v = 1'b0;
        chk("flush_empty", 32'(op_valid), 0);
        n = 0;
        while (!req_valid && n < 20) begin n++; tick(); end
        chk("flush_len", 32'(n), 32'(d1 - r));
        nd = n_del;
        for (int i = 0; i < 30 && n_del == nd; i++) tick();
        chk("redir_first", (n_del > nd) ? got_pc[nd] : 32'hDEAD_BEEF, 32'h100);

        // Redirect colliding with a decode handshake and a response.
        lat = 1;
        op_ready = 1'b1;
        for (int i = 0; i < 50 && !(op_valid && memq.size() > 0 && memq[0].due <= cyc); i++) tick();
        chk("wait_collide", 32'(op_valid && memq.size() > 0 && memq[0].due <= cyc), 1);
        nd = n_del;
        redir_v = 1'b1; redir_pc = 32'h200;
        tick();
        redir_v = 1'b0;
        chk("collide_nodel", 32'(n_del), 32'(nd));
        for (int i = 0; i < 30 && n_del == nd; i++) tick();
        chk("collide_first", (n_del > nd) ? got_pc[nd] : 32'hDEAD_BEEF, 32'h200);

        // Randomized traffic with random latencies and redirects.
        rand_rdy = 1; rand_dec = 1;
        for (int i = 0; i < 1500; i++) begin
            lat = $urandom_range(1, 4);
            redir_v = ($urandom_range(0, 24) == 0);
            redir_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            tick();
        end
        redir_v = 1'b0;
        rand_rdy = 0; rand_dec = 0; req_ready = 1'b1; op_ready = 1'b1;
        nd = n_del;
        for (int i = 0; i < 30; i++) tick();
        chk("drain_progress", 32'(n_del - nd >= 10), 1);

        // Reset while words are buffered and requests are outstanding.
        lat = 2; op_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(op_valid), 0);
        chk("mid_rst_addr", imem_addr, RST_PC);
        chk("mid_rst_inflight", 32'(u_dut.inflight_q), 0);
        chk("mid_rst_drop", 32'(u_dut.drop_q), 0);
        chk("mid_rst_req", 32'(req_valid), 1);
        op_ready = 1'b1;
        nd = n_del;
        for (int i = 0; i < 20 && n_del == nd; i++) tick();
        chk("mid_rst_first", (n_del > nd) ? got_pc[nd] : 32'hDEAD_BEEF, RST_PC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
